// File: rtl/l2_bank_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_bank_arb_pkg
// Description : Shared types and constants for the L2 bank arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_bank_arb_pkg;

    localparam int BANK_DATA_W = 32;
    localparam int BANK_BE_W   = 4;

    typedef enum logic [1:0] {
        START = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/l2_bank_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : l2_bank_rr_pick
// Description : Combinational rotating-priority picker; search starts at rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_bank_rr_pick #(
    parameter int NR_PORTS = 2,
    parameter int IDX_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic [NR_PORTS-1:0] req,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [NR_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]    idx,
    output logic                valid
);

    always_comb begin
        int w_p;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        w_p   = 0;
        for (int k = 0; k < NR_PORTS; k++) begin
            w_p = (int'(rr_ptr) + k) % NR_PORTS;
            if (!valid && req[w_p]) begin
                gnt[w_p] = 1'b1;
                idx      = w_p[IDX_W-1:0];
                valid    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2_bank_arbiter
// Description : Round-robin share of one single-port L2 SRAM bank, with a
//               zero-fill sequencer after reset and on request.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_bank_arbiter
    import l2_bank_arb_pkg::*;
#(
    parameter int NR_PORTS       = 2,
    parameter int ADDR_WIDTH     = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NR_PORTS-1:0]                   req_i,
    input  logic [NR_PORTS-1:0]                   wen_i,
    input  logic [NR_PORTS-1:0][BANK_BE_W-1:0]    be_i,
    input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
    input  logic [NR_PORTS-1:0][BANK_DATA_W-1:0]  wdata_i,
    output logic [NR_PORTS-1:0]                   gnt_o,
    output logic [NR_PORTS-1:0]                   rvalid_o,
    output logic [BANK_DATA_W-1:0]                rdata_o,
    input  logic                                  clear_i,
    output logic                                  clear_busy_o,
    output logic                                  bank_csn_o,
    output logic                                  bank_wen_o,
    output logic [BANK_BE_W-1:0]                  bank_be_o,
    output logic [ADDR_WIDTH-1:0]                 bank_addr_o,
    output logic [BANK_DATA_W-1:0]                bank_wdata_o,
    input  logic [BANK_DATA_W-1:0]                bank_rdata_i
);

    localparam int IDX_W = $clog2(NR_PORTS);

    arb_state_e             r_state;
    logic [IDX_W-1:0]       r_rr;
    logic [ADDR_WIDTH-1:0]  r_clr_cnt;
    logic                   r_resp_vld;
    logic [IDX_W-1:0]       r_resp_id;

    logic [NR_PORTS-1:0]    w_req_eff;
    logic [NR_PORTS-1:0]    w_gnt;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_valid;
    logic [NR_PORTS-1:0]    w_rvalid;

    // A clear request suppresses arbitration in the same cycle; requests stay pending.
    assign w_req_eff = (r_state == RUN && !clear_i) ? req_i : '0;

    l2_bank_rr_pick #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (IDX_W)
    ) u_rr_pick (
        .req    (w_req_eff),
        .rr_ptr (r_rr),
        .gnt    (w_gnt),
        .idx    (w_idx),
        .valid  (w_valid)
    );

    assign gnt_o        = w_gnt;
    assign clear_busy_o = (r_state != RUN);
    assign rdata_o      = bank_rdata_i;

    always_comb begin
        w_rvalid = '0;
        if (r_resp_vld) begin
            w_rvalid[r_resp_id] = 1'b1;
        end
    end
    assign rvalid_o = w_rvalid;

    always_comb begin
        bank_csn_o   = 1'b1;
        bank_wen_o   = 1'b1;
        bank_be_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        case (r_state)
            CLEAR: begin
                bank_csn_o  = 1'b0;
                bank_wen_o  = 1'b0;
                bank_be_o   = '1;
                bank_addr_o = r_clr_cnt;
            end
            RUN: begin
                bank_wen_o = 1'b0;
                if (w_valid) begin
                    bank_csn_o   = 1'b0;
                    bank_wen_o   = wen_i[w_idx];
                    bank_be_o    = be_i[w_idx];
                    bank_addr_o  = addr_i[w_idx];
                    bank_wdata_o = wdata_i[w_idx];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= START;
            r_rr       <= '0;
            r_clr_cnt  <= '0;
            r_resp_vld <= 1'b0;
            r_resp_id  <= '0;
        end else begin
            r_resp_vld <= w_valid;
            r_resp_id  <= w_idx;
            case (r_state)
                START: begin
                    r_clr_cnt <= '0;
                    r_state   <= CLEAR_ON_RESET ? CLEAR : RUN;
                end
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (&r_clr_cnt) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (clear_i) begin
                        r_clr_cnt <= '0;
                        r_state   <= CLEAR;
                    end else if (w_valid) begin
                        if (w_idx == IDX_W'(NR_PORTS - 1)) begin
                            r_rr <= '0;
                        end else begin
                            r_rr <= w_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= START;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_bank_arbiter
// Description : Self-checking bench: SRAM bank model plus a transaction-level
//               reference of arbitration, clearing and memory contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_bank_arbiter;

    localparam int N     = 3;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N-1:0]           req_i;
    logic [N-1:0]           wen_i;
    logic [N-1:0][3:0]      be_i;
    logic [N-1:0][AW-1:0]   addr_i;
    logic [N-1:0][31:0]     wdata_i;
    logic [N-1:0]           gnt_o;
    logic [N-1:0]           rvalid_o;
    logic [31:0]            rdata_o;
    logic                   clear_i;
    logic                   clear_busy_o;
    logic                   bank_csn_o;
    logic                   bank_wen_o;
    logic [3:0]             bank_be_o;
    logic [AW-1:0]          bank_addr_o;
    logic [31:0]            bank_wdata_o;
    logic [31:0]            bank_rdata_i;

    l2_bank_arbiter #(
        .NR_PORTS       (N),
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .wen_i        (wen_i),
        .be_i         (be_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .clear_i      (clear_i),
        .clear_busy_o (clear_busy_o),
        .bank_csn_o   (bank_csn_o),
        .bank_wen_o   (bank_wen_o),
        .bank_be_o    (bank_be_o),
        .bank_addr_o  (bank_addr_o),
        .bank_wdata_o (bank_wdata_o),
        .bank_rdata_i (bank_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Physical SRAM bank: single port, 1-cycle read, output holds across writes.
    logic [31:0] sram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = 32'hA5A5_0000 | i;
        bank_rdata_i = 32'h0;
    end
    always @(posedge clk_i) begin
        if (!bank_csn_o) begin
            if (!bank_wen_o) begin
                for (int b = 0; b < 4; b++)
                    if (bank_be_o[b]) sram[bank_addr_o][8*b +: 8] <= bank_wdata_o[8*b +: 8];
            end else begin
                bank_rdata_i <= sram[bank_addr_o];
            end
        end
    end

    // Reference model state
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [DEPTH];
    int          ref_rr;
    int          busy_left;
    logic [N-1:0] exp_rv;
    logic [31:0] exp_rd;
    bit          exp_rd_valid;
    logic [N-1:0] last_gnt;

    // Per-port pending transactions (held until granted)
    bit          pend [N];
    bit          pw   [N];
    logic [3:0]  pb   [N];
    logic [AW-1:0] pa [N];
    logic [31:0] pd   [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            req_i[p]   = pend[p];
            wen_i[p]   = pw[p];
            be_i[p]    = pb[p];
            addr_i[p]  = pa[p];
            wdata_i[p] = pd[p];
        end
    endtask

    task automatic clear_pend();
        for (int p = 0; p < N; p++) pend[p] = 1'b0;
    endtask

    task automatic set_pend(input int p, input bit rd, input logic [3:0] be,
                            input logic [AW-1:0] a, input logic [31:0] d);
        pend[p] = 1'b1; pw[p] = rd; pb[p] = be; pa[p] = a; pd[p] = d;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_gnt",    64'(gnt_o), 64'(0));
        chk("rst_rvalid", 64'(rvalid_o), 64'(0));
        chk("rst_busy",   64'(clear_busy_o), 64'(1));
        chk("rst_csn",    64'(bank_csn_o), 64'(1));
        chk("rst_wen",    64'(bank_wen_o), 64'(1));
        chk("rst_be",     64'(bank_be_o), 64'(0));
        chk("rst_addr",   64'(bank_addr_o), 64'(0));
        chk("rst_wdata",  64'(bank_wdata_o), 64'(0));
    endtask

    task automatic model_reset();
        busy_left    = DEPTH + 1;
        ref_rr       = 0;
        exp_rv       = '0;
        exp_rd_valid = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic step();
        int   g;
        bit   busy_e;
        bit   clr_cyc;
        logic [N-1:0] eg;
        drive();
        @(negedge clk_i);
        busy_e  = (busy_left > 0);
        clr_cyc = busy_e && (busy_left <= DEPTH);
        g  = -1;
        eg = '0;
        if (!busy_e && !clear_i) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(ref_rr + k) % N]) g = (ref_rr + k) % N;
            end
            if (g >= 0) eg[g] = 1'b1;
        end
        last_gnt = gnt_o;
        chk("busy",   64'(clear_busy_o), 64'(busy_e));
        chk("gnt",    64'(gnt_o), 64'(eg));
        chk("rvalid", 64'(rvalid_o), 64'(exp_rv));
        if (exp_rv != '0 && exp_rd_valid) chk("rdata", 64'(rdata_o), 64'(exp_rd));
        if (g >= 0) begin
            chk("csn_g",   64'(bank_csn_o), 64'(0));
            chk("wen_g",   64'(bank_wen_o), 64'(pw[g]));
            chk("addr_g",  64'(bank_addr_o), 64'(pa[g]));
            chk("be_g",    64'(bank_be_o), 64'(pb[g]));
            chk("wdata_g", 64'(bank_wdata_o), 64'(pd[g]));
        end else if (clr_cyc) begin
            chk("csn_c",   64'(bank_csn_o), 64'(0));
            chk("wen_c",   64'(bank_wen_o), 64'(0));
            chk("be_c",    64'(bank_be_o), 64'(4'hF));
            chk("addr_c",  64'(bank_addr_o), 64'(DEPTH - busy_left));
            chk("wdata_c", 64'(bank_wdata_o), 64'(0));
        end else begin
            chk("csn_idle", 64'(bank_csn_o), 64'(1));
        end
        @(posedge clk_i);
        exp_rv       = '0;
        exp_rd_valid = 1'b0;
        if (g >= 0) begin
            ref_rr    = (g + 1) % N;
            exp_rv[g] = 1'b1;
            if (pw[g]) begin
                exp_rd       = ref_mem[pa[g]];
                exp_rd_valid = 1'b1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (pb[g][b]) ref_mem[pa[g]][8*b +: 8] = pd[g][8*b +: 8];
            end
            pend[g] = 1'b0;
        end else if (clr_cyc) begin
            ref_mem[DEPTH - busy_left] = 32'h0;
        end
        if (busy_e) busy_left--;
        else if (clear_i) busy_left = DEPTH;
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hA5A5_0000 | i;
        for (int p = 0; p < N; p++) begin
            pend[p] = 1'b0; pw[p] = 1'b1; pb[p] = 4'h0; pa[p] = '0; pd[p] = '0;
        end
        rst_i   = 1'b1;
        clear_i = 1'b0;
        model_reset();
        drive();
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_outputs();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Post-reset zero-fill: START + 16 clear cycles
        repeat (DEPTH + 1) step();

        // Read addr 7 after the clear
        set_pend(0, 1'b1, 4'hF, 4'd7, 32'h0);
        step();
        chk("rd7_exp0", 64'(exp_rd), 64'(0));
        step();

        // Both ports requesting continuously: grants must alternate
        for (int i = 0; i < 6; i++) begin
            if (!pend[0]) set_pend(0, 1'b1, 4'hF, AW'(i), 32'h0);
            if (!pend[1]) set_pend(1, 1'b1, 4'hF, AW'(i + 8), 32'h0);
            step();
        end
        clear_pend();
        step();

        // Partial write then readback through the other port
        set_pend(0, 1'b0, 4'b0011, 4'd3, 32'hDEAD_BEEF);
        step();
        set_pend(1, 1'b1, 4'hF, 4'd3, 32'h0);
        step();
        chk("beef_model", 64'(exp_rd), 64'(32'h0000_BEEF));
        step();

        // Read followed by clear_i: response still delivered, clear cycle has no grant
        set_pend(0, 1'b1, 4'hF, 4'd3, 32'h0);
        step();
        set_pend(1, 1'b1, 4'hF, 4'd3, 32'h0);
        clear_i = 1'b1;
        step();
        chk("clr_nogrant", 64'(last_gnt), 64'(0));
        clear_i = 1'b0;
        repeat (DEPTH) step();
        step();
        step();
        chk("rd_after_clr", 64'(exp_rd), 64'(0));

        // Reset asserted mid-clear at clr_cnt = 9
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        repeat (9) step();
        rst_i = 1'b1;
        #1;
        chk_reset_outputs();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        repeat (DEPTH + 1) step();

        // Three ports: rr pointer at 1, ports 0 and 2 requesting
        set_pend(0, 1'b1, 4'hF, 4'd1, 32'h0);
        step();
        set_pend(0, 1'b1, 4'hF, 4'd2, 32'h0);
        set_pend(2, 1'b1, 4'hF, 4'd5, 32'h0);
        step();
        chk("rr3_first", 64'(last_gnt), 64'(3'b100));
        step();
        chk("rr3_second", 64'(last_gnt), 64'(3'b001));
        step();

        // Randomized traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < N; p++) begin
                if (!pend[p] && ($urandom % 3 == 0))
                    set_pend(p, 1'($urandom), 4'($urandom), AW'($urandom), $urandom);
            end
            clear_i = ($urandom % 80 == 0);
            step();
            clear_i = 1'b0;
        end
        clear_pend();
        repeat (DEPTH + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l2_bank_arbiter.md
# l2_bank_arbiter

Shares one interleaved L2 SRAM bank (the 32-bit, single-port, 1-cycle-read BRAM bank wrapper) between `NR_PORTS` TCDM-style requesters using round-robin arbitration. Returns read data and a response-valid exactly one cycle after each grant. Also owns a zero-fill sequencer that clears the whole bank after reset and on request. Sits between the L2 interconnect and each bank instance.

## Interface
- `NR_PORTS`, 2: number of requesters, ≥2.
- `ADDR_WIDTH`, 12: bank word-address width, matches the bank.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill the bank after every reset; 0 = go straight to service.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous active-high reset.
- `req_i` in `[NR_PORTS]`: request.
- `wen_i` in `[NR_PORTS]`: 0 = write, 1 = read.
- `be_i` in `[NR_PORTS][4]`: byte enables.
- `addr_i` in `[NR_PORTS][ADDR_WIDTH]`: word address.
- `wdata_i` in `[NR_PORTS][32]`: write data.
- `gnt_o` out `[NR_PORTS]`: grant, combinational, one-hot or zero.
- `rvalid_o` out `[NR_PORTS]`: response valid, one-hot or zero.
- `rdata_o` out 32: read data, shared, meaningful only with `rvalid_o`.
- `clear_i` in 1: single-cycle pulse requesting a bank zero-fill.
- `clear_busy_o` out 1: high while the arbiter is not servicing requests (START or CLEAR).
- `bank_csn_o` out 1: bank chip select, active-low.
- `bank_wen_o` out 1: bank write enable, active-low.
- `bank_be_o` out 4: bank byte enables.
- `bank_addr_o` out `ADDR_WIDTH`: bank address.
- `bank_wdata_o` out 32: bank write data.
- `bank_rdata_i` in 32: bank read data, valid 1 cycle after access.

## Operation
- FSM states:
  - START: reset state. No grants. `bank_csn_o`=1. Goes to CLEAR if `CLEAR_ON_RESET`, else RUN, on the next cycle.
  - CLEAR: each cycle drives `bank_csn_o`=0, `bank_wen_o`=0, `bank_be_o`=4'hF, `bank_addr_o`=`clr_cnt`, `bank_wdata_o`=0.
    - `clr_cnt` increments; at all-ones the state goes to RUN and the counter wraps to 0.
    - `gnt_o`=0 throughout.
  - RUN: arbitration.
    - Priority search starts at `rr_q` and proceeds cyclically; the first asserted `req_i` is granted.
    - The granted port's `wen`/`be`/`addr`/`wdata` drive the bank with `bank_csn_o`=0.
    - If no request, `bank_csn_o`=1 and the other bank outputs hold don't-care (driven 0).
    - `rr_q` ← (granted index + 1) mod `NR_PORTS` on a grant; it is unchanged when idle.
  - RUN with `clear_i`=1: no grant that cycle, `bank_csn_o`=1, next state CLEAR with `clr_cnt`=0. `clear_i` is ignored in START and CLEAR.
- Response: registered `resp_id_q`/`resp_vld_q` capture the granted index.
  - `rvalid_o[resp_id_q]` is asserted the following cycle, for reads and writes alike.
  - `rdata_o` = `bank_rdata_i` combinationally; it holds the old word for writes and is don't-care.
- A response from the last RUN grant is still delivered in the first CLEAR cycle.
- Reset mid-CLEAR or mid-RUN: all state is lost and the clear restarts from address 0 (if enabled). The in-flight `rvalid_o` is dropped.

## Timing
- Reset values:
  - `state`=START, `rr_q`=0, `clr_cnt`=0, `resp_vld_q`=0.
  - Outputs: `gnt_o`=0, `rvalid_o`=0, `clear_busy_o`=1, `bank_csn_o`=1, `bank_wen_o`=1, `bank_be_o`=0, `bank_addr_o`=0, `bank_wdata_o`=0.
- Grant: same cycle as `req_i` (combinational, no bubbles). Back-to-back grants allowed every cycle.
- `rvalid_o`: exactly 1 cycle after `gnt_o`; never stalls, no backpressure.
- Requesters hold `req_i` and payload until granted.
- Clear duration: 2^`ADDR_WIDTH` cycles.
  - After reset: `clear_busy_o` falls 2^`ADDR_WIDTH`+1 cycles after reset release (START + CLEAR).
  - After `clear_i`: `clear_busy_o` is high from the cycle after `clear_i`, for 2^`ADDR_WIDTH` cycles.
- Simultaneous `clear_i` with requests: `clear_i` wins; requests stay pending.

## Structure
- Package `l2_bank_arb_pkg`: `arb_state_e` {START, CLEAR, RUN}, `BANK_DATA_W`=32, `BANK_BE_W`=4.
- Sub-module `l2_bank_rr_pick`: combinational rotating-priority picker. Inputs `req`, `rr_ptr`; outputs `gnt` one-hot, `idx`, `valid`.
- Top holds the FSM, `clr_cnt`, `rr_q`, response registers and bank mux.

## Test plan
- `CLEAR_ON_RESET`=1, `ADDR_WIDTH`=4: release reset → `clear_busy_o`=1 for 17 cycles, 16 zero writes at addr 0..15, then a read of addr 7 returns 0 one cycle after grant.
- Both ports request continuously → grants alternate 0,1,0,1; each `rvalid_o` lags its grant by 1 cycle.
- Port 0 writes 0xDEADBEEF, be=4'b0011, addr 3; port 1 later reads addr 3 → `rdata_o`=0x0000BEEF with `rvalid_o[1]`.
- Read granted on the same cycle `clear_i` is pending on the next cycle: response still delivered. The cycle with `clear_i`=1 shows `gnt_o`=0. The subsequent read of the written address returns 0.
- Assert `rst_i` at `clr_cnt`=9 → outputs return to reset values immediately; after release the clear restarts at address 0.
- `NR_PORTS`=3, only ports 0 and 2 requesting, `rr_q`=1 → port 2 granted first, then port 0.
